// File: rtl/msx_mapper_detect_if.sv
// Loader-to-detector bus: streamed ROM bytes in, mapper decision and load size out.
interface msx_mapper_detect_if;
    logic        rom_load;
    logic        rom_wr;
    logic [7:0]  rom_data;
    logic [5:0]  mapper_detected;
    logic [2:0]  sram_size_detected;
    logic        detect_valid;
    logic [25:0] rom_size;

    modport master (
        output rom_load, rom_wr, rom_data,
        input  mapper_detected, sram_size_detected, detect_valid, rom_size
    );

    modport slave (
        input  rom_load, rom_wr, rom_data,
        output mapper_detected, sram_size_detected, detect_valid, rom_size
    );
endinterface

// File: rtl/msx_mapper_detect.sv
// ROM mapper autodetector: scans a streaming cartridge image for LD (nnnn),A
// bank-switch writes, votes per mapper type and decides when the load ends.
module msx_mapper_detect #(
    parameter logic [5:0]  UNKNOWN_CODE = 6'd9,
    parameter logic [25:0] LINEAR_MAX   = 26'd65536
) (
    input logic               clk,
    input logic               reset,
    msx_mapper_detect_if.slave bus
);
    typedef enum logic [2:0] {IDLE, OP, LO, HI, DECIDE} state_t;

    localparam int V_A8  = 0;
    localparam int V_A16 = 1;
    localparam int V_KON = 2;
    localparam int V_SCC = 3;

    state_t      state_q, state_d, scan_state;
    logic        load_q;
    logic [7:0]  lo_q, lo_d;
    logic [25:0] rom_size_q, rom_size_d;
    logic [5:0]  mapper_q, mapper_d;
    logic        valid_q, valid_d;
    logic [7:0]  votes_q [4];
    logic [7:0]  votes_d [4];

    logic        rise, fall, in_scan, take, vote_en;
    logic [15:0] addr;
    logic [3:0]  hit;
    logic [7:0]  best;
    logic [5:0]  decision;

    assign rise    = bus.rom_load & ~load_q;
    assign fall    = ~bus.rom_load & load_q;
    assign addr    = {bus.rom_data, lo_q};
    // A rising edge restarts the scan, so a byte in that cycle is parsed from OP.
    assign scan_state = rise ? OP : state_q;
    assign in_scan = (scan_state == OP) || (scan_state == LO) || (scan_state == HI);
    assign take    = bus.rom_wr & bus.rom_load & in_scan;
    assign vote_en = take & (scan_state == HI);

    always_comb begin
        hit = 4'b0000;
        case (addr)
            16'h4000, 16'h8000, 16'hA000: hit[V_KON] = 1'b1;
            16'h5000, 16'h9000, 16'hB000: hit[V_SCC] = 1'b1;
            16'h6800, 16'h7800:           hit[V_A8]  = 1'b1;
            16'h6000, 16'h7000: begin
                hit[V_A8]  = 1'b1;
                hit[V_A16] = 1'b1;
            end
            16'h77FF:                     hit[V_A16] = 1'b1;
            default:                      hit = 4'b0000;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_vote
            always_comb begin
                votes_d[gi] = rise ? 8'd0 : votes_q[gi];
                if (vote_en && hit[gi] && votes_d[gi] != 8'hFF)
                    votes_d[gi] = votes_d[gi] + 8'd1;
            end
        end
    endgenerate

    // Strict greater-than keeps the earlier (higher-priority) mapper on ties.
    always_comb begin
        best     = votes_q[V_SCC];
        decision = 6'd4;
        if (votes_q[V_KON] > best) begin
            best     = votes_q[V_KON];
            decision = 6'd3;
        end
        if (votes_q[V_A16] > best) begin
            best     = votes_q[V_A16];
            decision = 6'd2;
        end
        if (votes_q[V_A8] > best) begin
            best     = votes_q[V_A8];
            decision = 6'd1;
        end
        if (rom_size_q <= LINEAR_MAX)
            decision = 6'd6;
        else if (best == 8'd0)
            decision = UNKNOWN_CODE;
    end

    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        rom_size_d = rise ? 26'd0 : rom_size_q;
        mapper_d   = mapper_q;
        valid_d    = rise ? 1'b0 : valid_q;
        if (fall && in_scan) begin
            state_d = DECIDE;
        end else if (state_q == DECIDE && !rise) begin
            state_d  = IDLE;
            mapper_d = decision;
            valid_d  = 1'b1;
        end else begin
            state_d = scan_state;
            if (take) begin
                if (rom_size_d != 26'h3FF_FFFF)
                    rom_size_d = rom_size_d + 26'd1;
                case (scan_state)
                    OP: if (bus.rom_data == 8'h32) state_d = LO;
                    LO: begin
                        lo_d    = bus.rom_data;
                        state_d = HI;
                    end
                    HI:      state_d = OP;
                    default: state_d = scan_state;
                endcase
            end
        end
    end

    // load_q keeps tracking the pin through reset so a load in progress
    // at reset release is not mistaken for a fresh rising edge.
    always_ff @(posedge clk) begin
        load_q <= bus.rom_load;
        if (reset) begin
            state_q    <= IDLE;
            lo_q       <= 8'd0;
            rom_size_q <= 26'd0;
            mapper_q   <= UNKNOWN_CODE;
            valid_q    <= 1'b0;
            for (int i = 0; i < 4; i++) votes_q[i] <= 8'd0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            rom_size_q <= rom_size_d;
            mapper_q   <= mapper_d;
            valid_q    <= valid_d;
            for (int i = 0; i < 4; i++) votes_q[i] <= votes_d[i];
        end
    end

    assign bus.mapper_detected    = mapper_q;
    assign bus.sram_size_detected = 3'd0;
    assign bus.detect_valid       = valid_q;
    assign bus.rom_size           = rom_size_q;
endmodule
